// File: rtl/pll_reset_seq.sv
// pll_reset_seq: power-up and lock-supervision sequencer for the pixel-clock PLL.
// Runs entirely in the free-running reference clock domain (clkin).
//
// Ports:
//   clkin       in   reference clock, sole clock of this block
//   rst_n       in   synchronous active-low reset
//   locked      in   raw PLL LOCK, asynchronous to clkin
//   relock_req  in   single-cycle request to restart the sequence
//   pll_rst     out  PLL RST, active high (PLL needs PLLRST_ENA)
//   sys_rst_n   out  active-low video datapath reset, high only in RUN
//   fail        out  retries exhausted, sequencer parked in FAIL
//   state       out  current state (RESET=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAIL=4)
//   loss_cnt    out  saturating count of lock losses seen in RUN
//
// Parameter constraints: RST_CYCLES >= 2, LOCK_TIMEOUT >= 2, STABLE_CYCLES >= 1.
module pll_reset_seq #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned LOSS_W        = 8
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              relock_req,
  output logic              pll_rst,
  output logic              sys_rst_n,
  output logic              fail,
  output logic [2:0]        state,
  output logic [LOSS_W-1:0] loss_cnt
);

  // Shared timer is sized for the longest of the three intervals.
  localparam int unsigned MAX_RW  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_RW > STABLE_CYCLES) ? MAX_RW : STABLE_CYCLES;
  localparam int unsigned TIMER_W = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
  localparam int unsigned RETRY_W = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0]  LOSS_MAX    = {LOSS_W{1'b1}};

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [LOSS_W-1:0]    loss_q, loss_d;
  logic                 sync1_q, locked_s_q;
  logic                 pll_rst_q, pll_rst_d;
  logic                 sys_rst_n_q, sys_rst_n_d;
  logic                 fail_q, fail_d;

  // Next-state, counter and output decode; outputs are decoded from state_d
  // so they register on the same edge as the transition.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + TIMER_W'(1);
    retry_d     = retry_q;
    loss_d      = loss_q;
    pll_rst_d   = 1'b1;
    sys_rst_n_d = 1'b0;
    fail_d      = 1'b0;

    if (relock_req) begin
      state_d = ST_RESET;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still wins.
          if (locked_s_q) begin
            state_d = ST_STABLE;
          end else if (timer_q == LOCK_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ST_RESET;
            end
          end
        end
        ST_STABLE: begin
          // Lock loss on the final cycle still wins over entry to RUN.
          if (!locked_s_q) begin
            state_d = ST_WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!locked_s_q) begin
            state_d = ST_RESET;
            if (loss_q != LOSS_MAX) loss_d = loss_q + LOSS_W'(1);
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end

    // Timer restarts on every state change (and on relock); it is idle in
    // RUN and FAIL where no interval is being measured.
    if (relock_req || (state_d != state_q)) begin
      timer_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_FAIL)) begin
      timer_d = timer_q;
    end

    pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAIL);
    sys_rst_n_d = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  // State, counters, lock synchronizer and registered outputs.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      sync1_q     <= 1'b0;
      locked_s_q  <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      sync1_q     <= locked;
      locked_s_q  <= sync1_q;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign fail      = fail_q;
  assign state     = state_q;
  assign loss_cnt  = loss_q;

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Power-up and lock-supervision sequencer for the ECP5 EHXPLLL pixel-clock PLL (25 MHz in, 300/60 MHz out).
- Runs in the free-running 25 MHz input clock domain.
- Drives the PLL RST input and holds the video datapath in reset until lock has been stable for a programmable time.
- Re-runs the PLL reset on lock loss or timeout; declares failure after a bounded number of retries.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per attempt (≥2).
- LOCK_TIMEOUT, 65536: cycles to wait for lock before retrying (≥2).
- STABLE_CYCLES, 1024: contiguous locked cycles required before releasing sys_rst_n (≥1).
- MAX_RETRIES, 4: timeouts tolerated before FAIL.
- LOSS_W, 8: width of lock-loss counter.

Ports:
- clkin, input, 1: 25 MHz reference clock; sole clock.
- rst_n, input, 1: synchronous active-low reset.
- locked, input, 1: PLL LOCK, asynchronous to clkin.
- relock_req, input, 1: single-cycle request to restart the sequence.
- pll_rst, output, 1: to PLL RST, active high. The PLL instance must have PLLRST_ENA enabled.
- sys_rst_n, output, 1: active-low reset for the video datapath. Consumers in pixel domains synchronize its deassertion locally.
- fail, output, 1: retries exhausted.
- state, output, 3: current state encoding.
- loss_cnt, output, LOSS_W: count of lock losses while in RUN; saturating.

Behaviour:
- Reset (rst_n low at a clkin edge):
  - state=RESET, timer=0, retry_cnt=0, loss_cnt=0.
  - pll_rst=1, sys_rst_n=0, fail=0.
  - Sync flops cleared to 0.
- Input synchronizer:
  - locked passes through a 2-flop synchronizer to give locked_s; 2-cycle latency.
  - No other use of raw locked.
- State encoding: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- Output timing:
  - pll_rst and sys_rst_n are registered and computed from next-state, so they change on the same edge as the state transition. No decode glitches.
  - pll_rst=1 in RESET and FAIL.
  - sys_rst_n=1 only in RUN.
  - fail=1 only in FAIL.
- Timer: a single shared counter, cleared on every state change. Width is the clog2 of the largest of the three cycle parameters.
- RESET:
  - Timer counts 0..RST_CYCLES-1.
  - At RST_CYCLES-1, go to WAIT_LOCK. RESET therefore lasts exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - If locked_s=1, go to STABLE.
  - Else, at timer=LOCK_TIMEOUT-1:
    - If retry_cnt==MAX_RETRIES, go to FAIL.
    - Otherwise increment retry_cnt and go to RESET.
- STABLE:
  - If locked_s=0, go to WAIT_LOCK; the timeout restarts from 0.
  - Else, at timer=STABLE_CYCLES-1, go to RUN and clear retry_cnt.
- RUN:
  - If locked_s=0, go to RESET and increment loss_cnt.
  - loss_cnt saturates at all-ones; it never wraps.
  - sys_rst_n falls on the same edge as the transition.
- FAIL:
  - Terminal; PLL is held in reset.
  - Exit only via rst_n or relock_req.
- relock_req (highest priority after rst_n):
  - From any state, go to RESET on the next edge.
  - Clears timer, retry_cnt and fail. Does not clear loss_cnt.
  - Asserted while already in RESET, it restarts the RESET interval.
- Simultaneous events:
  - relock_req beats lock loss and timeout.
  - In WAIT_LOCK, locked_s=1 beats timeout in the same cycle.
  - In STABLE, lock loss on the final cycle beats entry to RUN.
- Mid-operation rst_n: returns to the reset values above in one cycle, regardless of state.
- Best-case power-up: with locked_s already high, sys_rst_n rises RST_CYCLES+1+STABLE_CYCLES edges after rst_n release.

Test Plan:
- Bench parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, LOSS_W=2.
- Normal power-up: locked tied 1, release rst_n.
  - pll_rst=1 for exactly 4 cycles, then 0.
  - state sequence 0→1→2→3.
  - sys_rst_n rises exactly 13 edges after rst_n release.
- Never lock: locked=0.
  - Three 24-cycle attempts, each with pll_rst high for 4 cycles.
  - FAIL (state=4, fail=1, pll_rst=1) at edge 72; it stays there for 200 further cycles.
  - A relock_req pulse then gives state=0 and fail=0 on the next edge.
- Glitch during STABLE: locked drops for 1 cycle on the 6th STABLE cycle.
  - Return to WAIT_LOCK, then re-enter STABLE.
  - RUN is reached only after 8 fresh contiguous locked cycles.
  - sys_rst_n never pulses high.
- Lock loss in RUN: drop locked.
  - sys_rst_n falls 3 edges after the drop (2 sync + 1 transition).
  - pll_rst rises on the same edge; loss_cnt 0→1.
  - Repeat 4 losses: loss_cnt saturates at 3.
- Late lock: locked rises on cycle 15 of the second WAIT_LOCK.
  - retry_cnt goes 1, then is cleared on RUN entry.
  - A subsequent 3-timeout sequence is required to reach FAIL.
- Mid-run reset: assert rst_n=0 for 1 cycle while in RUN.
  - Next edge: state=0, pll_rst=1, sys_rst_n=0, loss_cnt=0.
